seg7_scan: RTL and testbench



---
 rtl/seg7_scan.sv | 186 ++++++++++++++++++
 tb/tb_seg7_scan.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Time-multiplexed seven-segment display driver. Lights one digit at a time
// for SCAN_DIV clock cycles each, scanning digit 0 up to digit NDIGITS-1.
// All digit data is captured into shadow registers once per frame. A change in
// the counters upstream therefore never shows up halfway through a frame.
// Provides leading-zero blanking, per-digit blinking and decimal points.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   digits       BCD digit values, digit k = digits[4k+3:4k], digit 0 = LSD
//   dp_mask      decimal point request per digit
//   blink_mask   digit k blanks (segments and dp) while blink_phase=1
//   blink_phase  blink square wave from the timer logic
//   blank_lz     enable leading-zero blanking
//   seg          segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dp           decimal point, polarity per SEG_ACTIVE_LOW
//   an           digit enables, one-hot when active, polarity per AN_ACTIVE_LOW
//   frame_start  one-cycle pulse when a new frame (digit 0) begins
// -----------------------------------------------------------------------------
module seg7_scan #(
   parameter int NDIGITS        = 4,
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4*NDIGITS-1:0]   digits,
   input  logic [NDIGITS-1:0]     dp_mask,
   input  logic [NDIGITS-1:0]     blink_mask,
   input  logic                   blink_phase,
   input  logic                   blank_lz,
   output logic [6:0]             seg,
   output logic                   dp,
   output logic [NDIGITS-1:0]     an,
   output logic                   frame_start
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   localparam logic [PW-1:0]      PRE_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]      IDX_MAX = IW'(NDIGITS - 1);

   // Output levels that leave every segment and digit dark.
   localparam logic [6:0]         SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic               DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [NDIGITS-1:0] AN_OFF  = {NDIGITS{AN_ACTIVE_LOW}};

   // Scan timing
   logic [PW-1:0]         pre_q, pre_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  tick;
   logic                  frame_edge;

   // Frame snapshot
   logic                  valid_q;
   logic [4*NDIGITS-1:0]  sh_digits_q;
   logic [NDIGITS-1:0]    sh_dp_q;
   logic [NDIGITS-1:0]    sh_blink_q;
   logic                  sh_phase_q;
   logic                  sh_blz_q;

   // Registered outputs
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NDIGITS-1:0]    an_q, an_d;
   logic                  fs_q;

   // Current-digit selection
   logic [3:0]            cur_val;
   logic                  cur_dp;
   logic                  cur_blink;
   logic                  cur_lz;
   logic [NDIGITS-1:0]    an_sel;
   logic                  zero_run;
   logic                  blink_now;
   logic [6:0]            seg_log;
   logic                  dp_log;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
      case (v)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;   // 10..15 are not BCD: show blank
      endcase
   endfunction

   assign tick       = (pre_q == PRE_MAX);
   assign frame_edge = tick && (idx_q == IDX_MAX);

   always_comb begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
   end

   // Walk from the most significant digit down. zero_run stays high while
   // every digit seen so far (this one included) is zero, which is exactly
   // the leading-zero condition for the digit under the cursor.
   always_comb begin
      cur_val   = '0;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      cur_lz    = 1'b0;
      an_sel    = '0;
      zero_run  = 1'b1;
      for (int k = NDIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run & (sh_digits_q[4*k +: 4] == 4'd0);
         if (idx_q == IW'(k)) begin
            cur_val   = sh_digits_q[4*k +: 4];
            cur_dp    = sh_dp_q[k];
            cur_blink = sh_blink_q[k];
            cur_lz    = zero_run && (k != 0);
            an_sel[k] = 1'b1;
         end
      end
   end

   // Logical (active-high) levels first, polarity applied last. The anode
   // stays on for blanked digits so the scan duty cycle never changes.
   always_comb begin
      blink_now = cur_blink & sh_phase_q;
      seg_log   = (blink_now || (cur_lz && sh_blz_q)) ? 7'h00 : bcd_to_seg(cur_val);
      dp_log    = cur_dp & ~blink_now;
      if (valid_q) begin
         seg_d = SEG_ACTIVE_LOW ? ~seg_log : seg_log;
         dp_d  = SEG_ACTIVE_LOW ? ~dp_log  : dp_log;
         an_d  = AN_ACTIVE_LOW  ? ~an_sel  : an_sel;
      end else begin
         seg_d = SEG_OFF;
         dp_d  = DP_OFF;
         an_d  = AN_OFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q       <= '0;
         idx_q       <= IDX_MAX;
         valid_q     <= 1'b0;
         sh_digits_q <= '0;
         sh_dp_q     <= '0;
         sh_blink_q  <= '0;
         sh_phase_q  <= 1'b0;
         sh_blz_q    <= 1'b0;
         seg_q       <= SEG_OFF;
         dp_q        <= DP_OFF;
         an_q        <= AN_OFF;
         fs_q        <= 1'b0;
      end else begin
         pre_q <= pre_d;
         idx_q <= idx_d;
         fs_q  <= frame_edge;
         if (frame_edge) begin
            sh_digits_q <= digits;
            sh_dp_q     <= dp_mask;
            sh_blink_q  <= blink_mask;
            sh_phase_q  <= blink_phase;
            sh_blz_q    <= blank_lz;
            valid_q     <= 1'b1;
         end
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign seg         = seg_q;
   assign dp          = dp_q;
   assign an          = an_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan
// Two instances run side by side:
//   dut_a : NDIGITS=4, SCAN_DIV=4, active-low segments and anodes
//   dut_b : NDIGITS=4, SCAN_DIV=1, active-high segments and anodes
// Each stimulus process loads one frame's inputs just before a frame boundary
// and pushes the expected per-digit display words. Between boundaries it
// scribbles random values onto the inputs, and the snapshot must hide them.
// Each monitor derives the scan position from the cycle count since reset
// release. It pops one expected word per digit slot and compares every cycle.
// -----------------------------------------------------------------------------
module tb_seg7_scan;

   localparam int ND  = 4;
   localparam int S_A = 4;
   localparam int S_B = 1;

   logic        clk;
   logic        rst_n;
   logic        done;

   logic [15:0] digits_s [2];
   logic [3:0]  dp_s     [2];
   logic [3:0]  blink_s  [2];
   logic        phase_s  [2];
   logic        blz_s    [2];

   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b;
   logic [3:0]  an_a, an_b;
   logic        fs_a, fs_b;

   // Display word: {4'b0, an, seg, dp}
   logic [15:0] exp_q_a [$];
   logic [15:0] exp_q_b [$];
   logic [15:0] cur_exp [2];
   int          ncyc    [2];

   int          n_cmp;
   int          n_fail;

   logic [6:0]  seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   seg7_scan #(.NDIGITS(ND), .SCAN_DIV(S_A), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .digits(digits_s[0]), .dp_mask(dp_s[0]), .blink_mask(blink_s[0]),
      .blink_phase(phase_s[0]), .blank_lz(blz_s[0]),
      .seg(seg_a), .dp(dp_a), .an(an_a), .frame_start(fs_a)
   );

   seg7_scan #(.NDIGITS(ND), .SCAN_DIV(S_B), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .digits(digits_s[1]), .dp_mask(dp_s[1]), .blink_mask(blink_s[1]),
      .blink_phase(phase_s[1]), .blank_lz(blz_s[1]),
      .seg(seg_b), .dp(dp_b), .an(an_b), .frame_start(fs_b)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] exp_digit(input logic [15:0] dg, input logic [3:0] dpm,
                                             input logic [3:0] blm, input logic ph,
                                             input logic lz, input int k, input bit act_low);
      int         v;
      logic [6:0] s;
      logic       d;
      logic [3:0] a;
      v = int'((dg >> (4*k)) & 16'h000F);
      s = (v <= 9) ? seg_tbl[v] : 7'h00;
      // This digit and everything above it are zero
      if (lz && k > 0 && (dg >> (4*k)) == 16'h0000) s = 7'h00;
      d = dpm[k];
      if (blm[k] && ph) begin
         s = 7'h00;
         d = 1'b0;
      end
      a = 4'(1 << k);
      if (act_low) begin
         s = ~s;
         d = ~d;
         a = ~a;
      end
      return {4'b0000, a, s, d};
   endfunction

   function automatic logic [15:0] exp_dark(input bit act_low);
      return act_low ? {4'b0000, 4'hF, 7'h7F, 1'b1} : 16'h0000;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_frame(input int u, input int f);
      logic [15:0] dg;
      logic [3:0]  dpm, blm;
      logic        ph, lz;
      logic [15:0] e;
      if (u == 0 && f < 6) begin
         case (f)
            0:       begin dg = 16'h1234; dpm = 4'b0000; blm = 4'b0000; ph = 1'b0; lz = 1'b0; end
            1:       begin dg = 16'h5678; dpm = 4'b0000; blm = 4'b0000; ph = 1'b0; lz = 1'b0; end
            2:       begin dg = 16'h0005; dpm = 4'b0000; blm = 4'b0000; ph = 1'b0; lz = 1'b1; end
            3:       begin dg = 16'h0000; dpm = 4'b0000; blm = 4'b0000; ph = 1'b0; lz = 1'b1; end
            4:       begin dg = 16'h30B0; dpm = 4'b0011; blm = 4'b0001; ph = 1'b1; lz = 1'b0; end
            default: begin dg = 16'h0105; dpm = 4'b1111; blm = 4'b1010; ph = 1'b0; lz = 1'b1; end
         endcase
      end else begin
         dg  = 16'($urandom) >> (4 * $urandom_range(0, 3));
         dpm = 4'($urandom);
         blm = 4'($urandom);
         ph  = 1'($urandom);
         lz  = 1'($urandom);
      end
      digits_s[u] = dg;
      dp_s[u]     = dpm;
      blink_s[u]  = blm;
      phase_s[u]  = ph;
      blz_s[u]    = lz;
      for (int k = 0; k < ND; k++) begin
         e = exp_digit(dg, dpm, blm, ph, lz, k, (u == 0));
         if (u == 0) exp_q_a.push_back(e);
         else        exp_q_b.push_back(e);
      end
   endtask

   task automatic scribble(input int u);
      digits_s[u] = 16'($urandom);
      dp_s[u]     = 4'($urandom);
      blink_s[u]  = 4'($urandom);
      phase_s[u]  = 1'($urandom);
      blz_s[u]    = 1'($urandom);
   endtask

   // Called right after reset release. Boundary edges are posedges s, s+s*ND, ...
   // Inputs set after negedge n are sampled at posedge n+1.
   task automatic stim(input int u, input int s);
      int n;
      int f;
      n = 0;
      f = 0;
      load_frame(u, f);
      f++;
      forever begin
         @(negedge clk);
         if (!rst_n || done) return;
         n++;
         if (n >= s && ((n - s + 1) % (s * ND)) == 0) begin
            load_frame(u, f);
            f++;
         end else if (n >= s && $urandom_range(0, 1) == 1) begin
            scribble(u);
         end
      end
   endtask

   // ---------------- scoreboard monitors ----------------
   task automatic monitor(input int u, input int s, input logic [15:0] act, input logic fs);
      int n;
      int m;
      if (!rst_n) begin
         ncyc[u] = 0;
         if (u == 0) exp_q_a.delete();
         else        exp_q_b.delete();
         return;
      end
      if (done) return;
      ncyc[u]++;
      n = ncyc[u];
      check($sformatf("u%0d frame_start n=%0d", u, n), {15'b0, fs},
            {15'b0, (n >= s) && (((n - s) % (s * ND)) == 0)});
      if (n <= s) begin
         check($sformatf("u%0d dark before first frame n=%0d", u, n), act, exp_dark(u == 0));
      end else begin
         m = n - s - 1;
         if ((m % s) == 0) begin
            if ((u == 0 && exp_q_a.size() == 0) || (u == 1 && exp_q_b.size() == 0)) begin
               n_cmp++;
               n_fail++;
               $display("FAIL u%0d scoreboard: got empty queue, expected a pending digit (t=%0t)", u, $time);
               cur_exp[u] = 16'hxxxx;
            end else if (u == 0) begin
               cur_exp[u] = exp_q_a.pop_front();
            end else begin
               cur_exp[u] = exp_q_b.pop_front();
            end
         end
         check($sformatf("u%0d digit%0d {an,seg,dp}", u, (m / s) % ND), act, cur_exp[u]);
      end
   endtask

   always @(negedge clk) monitor(0, S_A, {4'b0000, an_a, seg_a, dp_a}, fs_a);
   always @(negedge clk) monitor(1, S_B, {4'b0000, an_b, seg_b, dp_b}, fs_b);

   // ---------------- sequencing ----------------
   task automatic check_dark_now(input string tag);
      check({tag, " a outputs"}, {4'b0000, an_a, seg_a, dp_a}, exp_dark(1'b1));
      check({tag, " a frame_start"}, {15'b0, fs_a}, 16'h0000);
      check({tag, " b outputs"}, {4'b0000, an_b, seg_b, dp_b}, exp_dark(1'b0));
      check({tag, " b frame_start"}, {15'b0, fs_b}, 16'h0000);
   endtask

   // The reset is asserted partway between edges, and the outputs are checked
   // 1 time unit later, before any clock edge.
   task automatic run_phase(input int cycles, input string tag);
      @(negedge clk);
      #1 rst_n = 1'b1;
      fork
         stim(0, S_A);
         stim(1, S_B);
      join_none
      repeat (cycles) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_dark_now(tag);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      done   = 1'b0;
      rst_n  = 1'b1;
      for (int u = 0; u < 2; u++) begin
         digits_s[u] = '0;
         dp_s[u]     = '0;
         blink_s[u]  = '0;
         phase_s[u]  = 1'b0;
         blz_s[u]    = 1'b0;
         ncyc[u]     = 0;
         cur_exp[u]  = '0;
      end
      #2 rst_n = 1'b0;
      #1 check_dark_now("reset before first edge");
      repeat (3) @(negedge clk);
      run_phase(300, "mid-frame reset 1");
      run_phase(200, "mid-frame reset 2");
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
